clock_mode_ctrl: RTL and testbench

- Central mode and sequencing controller for the 24-hour digital clock.
- Turns debounced button levels into a run/set/alarm-edit state machine and drives one-cycle increment strobes to the BCD time-keeping datapath.
- Owns the alarm time registers and the alarm-enable flag, detects alarm match, and times the ringing interval.
- Provides blink and select information to the 7-segment display mux.

---
 rtl/clock_mode_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: run/set/alarm-edit mode FSM, alarm time registers, alarm match and ring timer for a 24h clock.
// Latency: all outputs registered; increment strobes appear in the cycle after the press cycle.
// Backpressure: none; button levels and tick_1hz are sampled every cycle and never stalled.
module clock_mode_ctrl #(
    parameter int TIMEOUT_S    = 30,
    parameter int RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [7:0] alm_hour,
    output logic [7:0] alm_min,
    output logic       alarm_en,
    output logic       ringing,
    output logic       disp_alarm,
    output logic [2:0] blink_mask,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        ALM_HOUR = 3'd4,
        ALM_MIN  = 3'd5
    } state_t;

    // Terminal counts: the event fires on the tick that would make the count reach the parameter.
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_S - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    state_t     st;
    state_t     state_nxt;
    logic       prev_mode;
    logic       prev_inc;
    logic       prev_alarm;
    logic [7:0] to_cnt;
    logic [7:0] to_nxt;
    logic [7:0] ring_cnt;
    logic       blink_phase;
    logic       phase_nxt;
    logic       match_d;

    logic press_mode;
    logic press_inc;
    logic press_alarm;
    logic any_press;
    logic ring_hold;
    logic act_mode;
    logic act_inc;
    logic act_alarm;
    logic tick_edit;
    logic timeout_hit;
    logic state_chg;
    logic match;
    logic clear_ring;

    assign state = st;

    // BCD +1 with wrap from 'last' back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Which {hour, min, sec} digit pair is being edited in a given state.
    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            SET_HOUR, ALM_HOUR: return 3'b100;
            SET_MIN,  ALM_MIN:  return 3'b010;
            SET_SEC:            return 3'b001;
            default:            return 3'b000;
        endcase
    endfunction

    // Press detection, press arbitration, next state, timeout and blink bookkeeping.
    always_comb begin
        press_mode  = btn_mode  & ~prev_mode;
        press_inc   = btn_inc   & ~prev_inc;
        press_alarm = btn_alarm & ~prev_alarm;
        any_press   = press_mode | press_inc | press_alarm;

        // While ringing, a press is consumed purely as "silence".
        ring_hold = ringing & any_press;
        act_mode  = press_mode & ~ring_hold;
        act_inc   = press_inc & ~press_mode & ~ring_hold;
        act_alarm = press_alarm & ~ring_hold;

        tick_edit   = tick_1hz & (st != RUN);
        timeout_hit = tick_edit & (to_cnt == TO_LAST) & ~any_press;

        state_nxt = st;
        case (st)
            RUN:      if (act_mode) state_nxt = SET_HOUR;
            SET_HOUR: if (act_mode) state_nxt = SET_MIN;  else if (timeout_hit) state_nxt = RUN;
            SET_MIN:  if (act_mode) state_nxt = SET_SEC;  else if (timeout_hit) state_nxt = RUN;
            SET_SEC:  if (act_mode) state_nxt = ALM_HOUR; else if (timeout_hit) state_nxt = RUN;
            ALM_HOUR: if (act_mode) state_nxt = ALM_MIN;  else if (timeout_hit) state_nxt = RUN;
            ALM_MIN:  if (act_mode | timeout_hit) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
        state_chg = (state_nxt != st);

        if (any_press | state_chg)
            to_nxt = 8'd0;
        else if (tick_edit)
            to_nxt = to_cnt + 8'd1;
        else
            to_nxt = to_cnt;

        if (state_chg)
            phase_nxt = 1'b1;
        else if (tick_1hz)
            phase_nxt = ~blink_phase;
        else
            phase_nxt = blink_phase;

        match = (st == RUN) & alarm_en & (cur_hour == alm_hour) & (cur_min == alm_min)
              & (cur_sec == 8'h00);

        // Disarming or leaving RUN always beats a fresh match edge.
        clear_ring = ring_hold | (act_alarm & alarm_en) | (state_nxt != RUN);
    end

    // Mode FSM with registered outputs, alarm registers and ring timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= RUN;
            prev_mode   <= 1'b1;
            prev_inc    <= 1'b1;
            prev_alarm  <= 1'b1;
            to_cnt      <= 8'd0;
            ring_cnt    <= 8'd0;
            blink_phase <= 1'b1;
            match_d     <= 1'b0;
            run_en      <= 1'b1;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            clr_sec     <= 1'b0;
            alm_hour    <= 8'h07;
            alm_min     <= 8'h00;
            alarm_en    <= 1'b0;
            ringing     <= 1'b0;
            disp_alarm  <= 1'b0;
            blink_mask  <= 3'b000;
        end else begin
            st          <= state_nxt;
            prev_mode   <= btn_mode;
            prev_inc    <= btn_inc;
            prev_alarm  <= btn_alarm;
            to_cnt      <= to_nxt;
            blink_phase <= phase_nxt;
            match_d     <= match;

            run_en     <= (state_nxt == RUN);
            disp_alarm <= (state_nxt == ALM_HOUR) | (state_nxt == ALM_MIN);
            blink_mask <= field_of(state_nxt) & {3{~phase_nxt}};

            inc_hour <= act_inc & (st == SET_HOUR);
            inc_min  <= act_inc & (st == SET_MIN);
            clr_sec  <= act_inc & (st == SET_SEC);

            if (act_inc && st == ALM_HOUR)
                alm_hour <= bcd_inc(alm_hour, 8'h23);
            if (act_inc && st == ALM_MIN)
                alm_min <= bcd_inc(alm_min, 8'h59);

            if (act_alarm)
                alarm_en <= ~alarm_en;

            if (clear_ring) begin
                ringing <= 1'b0;
            end else if (match & ~match_d) begin
                ringing  <= 1'b1;
                ring_cnt <= 8'd0;
            end else if (ringing & tick_1hz) begin
                if (ring_cnt == RING_LAST)
                    ringing <= 1'b0;
                else
                    ring_cnt <= ring_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed table, corner sequences and randomized run against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_clock_mode_ctrl;

    localparam int TIMEOUT_S    = 30;
    localparam int RING_SECONDS = 60;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_alarm;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [7:0] alm_hour;
    logic [7:0] alm_min;
    logic       alarm_en;
    logic       ringing;
    logic       disp_alarm;
    logic [2:0] blink_mask;
    logic [2:0] state;

    clock_mode_ctrl #(
        .TIMEOUT_S    (TIMEOUT_S),
        .RING_SECONDS (RING_SECONDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_alarm  (btn_alarm),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .run_en     (run_en),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .alm_hour   (alm_hour),
        .alm_min    (alm_min),
        .alarm_en   (alarm_en),
        .ringing    (ringing),
        .disp_alarm (disp_alarm),
        .blink_mask (blink_mask),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit strobe_seen;

    // Behavioural model: mode index 0..5, alarm time held as plain integers.
    int m_st, m_ah, m_am, m_rcnt, m_to;
    bit m_en, m_ring, m_ph, m_md, m_pm, m_pi, m_pa, e_ih, e_im, e_cs;

    typedef struct {
        int m; int i; int a; int t;
        int st; int run; int strb; int disp; int mask;
    } vec_t;
    vec_t tbl[23];

    function automatic vec_t mk(input int m, input int i, input int a, input int t, input int st,
                                input int run, input int strb, input int disp, input int mask);
        vec_t v;
        v.m = m; v.i = i; v.a = a; v.t = t;
        v.st = st; v.run = run; v.strb = strb; v.disp = disp; v.mask = mask;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ah = 7; m_am = 0; m_rcnt = 0; m_to = 0;
        m_en = 0; m_ring = 0; m_ph = 1; m_md = 0;
        m_pm = 1; m_pi = 1; m_pa = 1;
        e_ih = 0; e_im = 0; e_cs = 0;
    endtask

    task automatic model_step();
        bit pm, pi, pa, any, match, old_en, cleared;
        int nst;
        pm = btn_mode && !m_pm;
        pi = btn_inc && !m_pi;
        pa = btn_alarm && !m_pa;
        any = pm || pi || pa;
        match = (m_st == 0) && m_en && (cur_hour == to_bcd(m_ah)) && (cur_min == to_bcd(m_am))
                && (cur_sec == 8'h00);
        old_en = m_en;
        e_ih = 0; e_im = 0; e_cs = 0;
        nst = m_st;
        if (m_ring && any) begin
            m_ring = 0;
        end else begin
            if (pa) m_en = !m_en;
            if (pm) nst = (m_st + 1) % 6;
            else if (pi) begin
                case (m_st)
                    1: e_ih = 1;
                    2: e_im = 1;
                    3: e_cs = 1;
                    4: m_ah = (m_ah + 1) % 24;
                    5: m_am = (m_am + 1) % 60;
                    default: ;
                endcase
            end
            if (!any && tick_1hz && m_st != 0 && m_to + 1 == TIMEOUT_S) nst = 0;
            cleared = (pa && old_en) || (nst != 0);
            if (cleared) m_ring = 0;
            else if (match && !m_md) begin
                m_ring = 1;
                m_rcnt = 0;
            end else if (m_ring && tick_1hz) begin
                m_rcnt++;
                if (m_rcnt >= RING_SECONDS) m_ring = 0;
            end
        end
        if (any || nst != m_st) m_to = 0;
        else if (tick_1hz && m_st != 0) m_to++;
        if (nst != m_st) m_ph = 1;
        else if (tick_1hz) m_ph = !m_ph;
        m_md = match;
        m_pm = btn_mode; m_pi = btn_inc; m_pa = btn_alarm;
        m_st = nst;
    endtask

    function automatic logic [28:0] model_vec();
        logic [2:0] f;
        f = (m_st == 1 || m_st == 4) ? 3'b100 :
            (m_st == 2 || m_st == 5) ? 3'b010 :
            (m_st == 3)              ? 3'b001 : 3'b000;
        return {3'(m_st), m_st == 0, e_ih, e_im, e_cs, to_bcd(m_ah), to_bcd(m_am),
                m_en, m_ring, m_st >= 4, f & {3{~m_ph}}};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {state, run_en, inc_hour, inc_min, clr_sec, alm_hour, alm_min,
                alarm_en, ringing, disp_alarm, blink_mask};
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        if (inc_hour || inc_min) strobe_seen = 1;
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic press(input int which);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_inc = 1'b1;
        else btn_alarm = 1'b1;
        cyc();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
        cyc();
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            m  i  a  t  st run strb disp mask
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 2, 0, 2, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 2, 0, 2, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 2, 0, 2, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 0, 0, 3, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 3, 0, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 3, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 3, 0, 0, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 3, 0, 0, 0, 0);
        tbl[20] = mk(1, 0, 0, 0, 4, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 0, 0, 4, 0, 0, 1, 0);
        tbl[22] = mk(0, 0, 0, 1, 4, 0, 0, 1, 4);

        rst = 1'b1; tick_1hz = 1'b0;
        btn_mode = 1'b1; btn_inc = 1'b0; btn_alarm = 1'b0;
        cur_hour = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
        strobe_seen = 0;
        model_reset();

        // Reset values, with btn_mode held across reset release.
        cyc();
        cyc();
        chk("rst_state", state, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_alm_hour", alm_hour, 8'h07);
        chk("rst_alm_min", alm_min, 8'h00);
        chk("rst_flags", {alarm_en, ringing, disp_alarm, blink_mask}, 0);
        rst = 1'b0;

        // Directed table: mode walk, inc_min pulses, mode+inc collision, blink.
        for (int k = 0; k < 23; k++) begin
            btn_mode  = (tbl[k].m != 0);
            btn_inc   = (tbl[k].i != 0);
            btn_alarm = (tbl[k].a != 0);
            tick_1hz  = (tbl[k].t != 0);
            cyc();
            chk($sformatf("tbl%0d_state", k), state, tbl[k].st);
            chk($sformatf("tbl%0d_run_en", k), run_en, tbl[k].run);
            chk($sformatf("tbl%0d_strobes", k), {inc_hour, inc_min, clr_sec}, tbl[k].strb);
            chk($sformatf("tbl%0d_disp", k), disp_alarm, tbl[k].disp);
            chk($sformatf("tbl%0d_mask", k), blink_mask, tbl[k].mask);
        end
        btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0; tick_1hz = 1'b0;
        cyc();

        // Alarm hour/minute BCD wrap in the alarm edit states.
        strobe_seen = 0;
        for (int k = 0; k < 16; k++) press(1);
        chk("alm_hour_23", alm_hour, 8'h23);
        press(1);
        chk("alm_hour_wrap", alm_hour, 8'h00);
        for (int k = 0; k < 7; k++) press(1);
        press(0);
        chk("alm_min_state", state, 5);
        for (int k = 0; k < 59; k++) press(1);
        chk("alm_min_59", alm_min, 8'h59);
        press(1);
        chk("alm_min_wrap", alm_min, 8'h00);
        chk("alm_no_time_strobe", strobe_seen, 0);
        press(0);
        chk("back_to_run", state, 0);

        // Edit timeout, restarted by a press at tick 29, blink alternation.
        press(0);
        chk("to_enter", state, 1);
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk($sformatf("blink_t%0d", k), blink_mask, (k % 2 == 1) ? 4 : 0);
        end
        chk("to_29_state", state, 1);
        press(1);
        for (int k = 0; k < 29; k++) tick();
        chk("to_restart_state", state, 1);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk("to_30_state", state, 0);
        chk("to_30_run_en", run_en, 1);
        cyc();

        // Alarm match, ring duration, silencing.
        press(2);
        chk("alarm_armed", alarm_en, 1);
        cur_hour = 8'h07; cur_min = 8'h00; cur_sec = 8'h00;
        cyc();
        chk("ring_start", ringing, 1);
        for (int k = 0; k < 59; k++) tick();
        chk("ring_59", ringing, 1);
        tick();
        chk("ring_60", ringing, 0);
        cur_sec = 8'h01; cyc(); cur_sec = 8'h00; cyc();
        chk("ring_again", ringing, 1);
        press(0);
        chk("ring_mode_silence", ringing, 0);
        chk("ring_mode_state", state, 0);
        cur_sec = 8'h01; cyc(); cur_sec = 8'h00; cyc();
        chk("ring_third", ringing, 1);
        press(2);
        chk("ring_alarm_silence", ringing, 0);
        chk("ring_alarm_kept", alarm_en, 1);
        // Re-trigger while ringing restarts the interval.
        cur_sec = 8'h01; cyc(); cur_sec = 8'h00; cyc();
        for (int k = 0; k < 40; k++) tick();
        cur_sec = 8'h01; cyc(); cur_sec = 8'h00; cyc();
        for (int k = 0; k < 40; k++) tick();
        chk("ring_restart_80", ringing, 1);
        for (int k = 0; k < 20; k++) tick();
        chk("ring_restart_end", ringing, 0);

        // Randomized run against the model; quiet segments let timeouts happen.
        for (int seg = 0; seg < 30; seg++) begin
            bit quiet;
            quiet = ($urandom_range(0, 2) == 0);
            for (int n = 0; n < 100; n++) begin
                btn_mode  = !quiet && ($urandom_range(0, 15) == 0);
                btn_inc   = !quiet && ($urandom_range(0, 3) == 0);
                btn_alarm = !quiet && ($urandom_range(0, 19) == 0);
                tick_1hz  = ($urandom_range(0, 1) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    cur_hour = to_bcd(m_ah);
                    cur_min  = to_bcd(m_am);
                    cur_sec  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h01;
                end else if ($urandom_range(0, 7) == 0) begin
                    cur_hour = to_bcd($urandom_range(0, 23));
                    cur_min  = to_bcd($urandom_range(0, 59));
                    cur_sec  = to_bcd($urandom_range(0, 59));
                end
                cyc();
            end
        end

        // Asynchronous reset mid-operation.
        btn_mode = 1'b1; btn_inc = 1'b0; btn_alarm = 1'b0; tick_1hz = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_state", state, 0);
        chk("arst_outputs", 32'(dut_vec()), 32'(model_vec()));
        cyc();
        rst = 1'b0;
        cyc();
        chk("arst_held_mode", state, 0);
        btn_mode = 1'b0;
        cyc();
        press(0);
        chk("arst_press", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
